// File: rtl/decode_pkg.sv
// Shared decode types: format codes, opcodes, immediate widths, buffer entry.
// Used by imm_extract and imm_field_decode.
package decode_pkg;

    localparam int IMM12_W = 12;
    localparam int IMM20_W = 20;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } imm_fmt_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [31:0]        instr;
        imm_fmt_e           fmt;
        logic [IMM12_W-1:0] imm12;
        logic [IMM20_W-1:0] imm20;
        logic               illegal;
    } dec_entry_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational opcode classifier and raw immediate extractor.
// ILLEGAL_OPCODE_CHECK_EN: unlisted opcodes flag illegal instead of decoding as I.
module imm_extract
    import decode_pkg::*;
(
    input  logic [31:0]        instr,
    output imm_fmt_e           fmt,
    output logic [IMM12_W-1:0] imm12,
    output logic [IMM20_W-1:0] imm20,
    output logic               illegal
);

    always_comb begin
        fmt     = FMT_I;
        illegal = 1'b0;
        unique case (instr[6:0])
            OP_OP:     fmt = FMT_R;
            OP_IMM,
            OP_LOAD,
            OP_JALR,
            OP_SYSTEM,
            OP_FENCE:  fmt = FMT_I;
            OP_STORE:  fmt = FMT_S;
            OP_BRANCH: fmt = FMT_B;
            OP_LUI,
            OP_AUIPC:  fmt = FMT_U;
            OP_JAL:    fmt = FMT_J;
            default: begin
`ifdef ILLEGAL_OPCODE_CHECK_EN
                fmt     = FMT_ILL;
                illegal = 1'b1;
`else
                fmt     = FMT_I;
`endif
            end
        endcase
    end

    // Immediates are raw bit gathers; sign extension and shifts live downstream.
    always_comb begin
        imm12 = '0;
        imm20 = '0;
        unique case (fmt)
            FMT_I: imm12 = instr[31:20];
            FMT_S: imm12 = {instr[31:25], instr[11:7]};
            FMT_B: imm12 = {instr[31], instr[7], instr[30:25], instr[11:8]};
            FMT_U: imm20 = instr[31:12];
            FMT_J: imm20 = {instr[31], instr[19:12], instr[20], instr[30:21]};
            default: begin
                imm12 = '0;
                imm20 = '0;
            end
        endcase
    end

endmodule

// File: rtl/imm_field_decode.sv
// Decode stage: classify format, extract immediates, hold in a 2-entry skid buffer.
// ILLEGAL_OPCODE_CHECK_EN selects illegal-opcode flagging in imm_extract.
module imm_field_decode
    import decode_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [PC_WIDTH-1:0] out_pc,
    output imm_fmt_e            out_fmt,
    output logic [IMM12_W-1:0]  out_imm12,
    output logic [IMM20_W-1:0]  out_imm20,
    output logic                out_illegal
);

    buf_state_e          state_q;
    buf_state_e          state_d;
    dec_entry_t          dec;
    dec_entry_t          main_q;
    dec_entry_t          skid_q;
    logic [PC_WIDTH-1:0] main_pc;
    logic [PC_WIDTH-1:0] skid_pc;
    logic                accept;
    logic                pop;

    imm_extract u_extract (
        .instr   (in_instr),
        .fmt     (dec.fmt),
        .imm12   (dec.imm12),
        .imm20   (dec.imm20),
        .illegal (dec.illegal)
    );

    assign dec.instr = in_instr;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BUF_EMPTY: if (accept) state_d = BUF_ONE;
            BUF_ONE: begin
                if (accept && !pop) begin
                    state_d = BUF_TWO;
                end else if (!accept && pop) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: if (pop) state_d = BUF_ONE;
            default: state_d = BUF_EMPTY;
        endcase
        if (flush) begin
            state_d = BUF_EMPTY;
        end
    end

    // Handshake outputs depend on registered state only.
    always_comb begin
        in_ready  = (state_q != BUF_TWO);
        out_valid = (state_q != BUF_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q  <= '0;
            skid_q  <= '0;
            main_pc <= '0;
            skid_pc <= '0;
        end else if (!flush) begin
            if (accept && (state_q == BUF_EMPTY || pop)) begin
                main_q  <= dec;
                main_pc <= in_pc;
            end else if (pop && state_q == BUF_TWO) begin
                main_q  <= skid_q;
                main_pc <= skid_pc;
            end
            if (accept && !pop && state_q == BUF_ONE) begin
                skid_q  <= dec;
                skid_pc <= in_pc;
            end
        end
    end

    assign out_instr   = main_q.instr;
    assign out_pc      = main_pc;
    assign out_fmt     = main_q.fmt;
    assign out_imm12   = main_q.imm12;
    assign out_imm20   = main_q.imm20;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_field_decode.sv
// Scoreboard bench for imm_field_decode with directed decode/backpressure/flush/reset vectors.
module tb_imm_field_decode;
    import decode_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic [11:0] imm12;
        logic [19:0] imm20;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    imm_fmt_e    out_fmt;
    logic [11:0] out_imm12;
    logic [19:0] out_imm20;
    logic        out_illegal;

    int   total  = 0;
    int   passed = 0;
    int   n_pops = 0;
    exp_t cur_exp;
    exp_t q[$];

    always #5 clk = ~clk;

    imm_field_decode #(.PC_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_fmt     (out_fmt),
        .out_imm12   (out_imm12),
        .out_imm20   (out_imm20),
        .out_illegal (out_illegal)
    );

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [2:0] fmt, input logic [11:0] imm12,
                                input logic [19:0] imm20, input logic ill);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.fmt   = fmt;
        e.imm12 = imm12;
        e.imm20 = imm20;
        e.ill   = ill;
        return e;
    endfunction

    function automatic logic [99:0] out_word();
        return {out_instr, out_pc, 3'(out_fmt), out_imm12, out_imm20, out_illegal};
    endfunction

    // Monitor: compare on every pop, then record whatever was accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && !flush) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 128'(out_valid & out_ready), 128'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("pop", 128'(out_word()), 128'(e));
                    n_pops++;
                end
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && in_ready) begin
                q.push_back(cur_exp);
            end
        end
    end

    task automatic offer(input exp_t e);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_instr = e.instr;
        in_pc    = e.pc;
        cur_exp  = e;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("offer_timeout", 128'(in_ready), 128'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    exp_t v_ill;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        cur_exp   = '0;
`ifdef ILLEGAL_OPCODE_CHECK_EN
        v_ill = mk(32'hABC0007F, 32'h11C, 3'd7, 12'h000, 20'h0, 1'b1);
`else
        v_ill = mk(32'hABC0007F, 32'h11C, 3'd1, 12'hABC, 20'h0, 1'b0);
`endif
        #1;
        check("reset_valid", 128'(out_valid), 128'd0);
        check("reset_ready", 128'(in_ready), 128'd1);
        check("reset_data", 128'(out_word()), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Decode of every format at full throughput
        offer(mk(32'hFFF00093, 32'h100, 3'd1, 12'hFFF, 20'h0, 1'b0));
        check("latency_valid", 128'(out_valid), 128'd1);
        offer(mk(32'hFE20AE23, 32'h104, 3'd2, 12'hFFC, 20'h0, 1'b0));
        offer(mk(32'hFE000CE3, 32'h108, 3'd3, 12'hFFC, 20'h0, 1'b0));
        offer(mk(32'h123450B7, 32'h10C, 3'd4, 12'h000, 20'h12345, 1'b0));
        offer(mk(32'hFFDFF06F, 32'h110, 3'd5, 12'h000, 20'hFFFFE, 1'b0));
        offer(mk(32'h002081B3, 32'h114, 3'd0, 12'h000, 20'h0, 1'b0));
        offer(mk(32'h00000017, 32'h118, 3'd4, 12'h000, 20'h0, 1'b0));
        offer(v_ill);
        idle(3);

        // Backpressure: two fit, third stalls until the consumer drains
        out_ready = 1'b0;
        offer(mk(32'h00100093, 32'h200, 3'd1, 12'h001, 20'h0, 1'b0));
        offer(mk(32'h00200113, 32'h204, 3'd1, 12'h002, 20'h0, 1'b0));
        in_valid = 1'b1;
        in_instr = 32'h00300193;
        in_pc    = 32'h208;
        cur_exp  = mk(32'h00300193, 32'h208, 3'd1, 12'h003, 20'h0, 1'b0);
        check("bp_ready_low", 128'(in_ready), 128'd0);
        idle(2);
        check("bp_hold", 128'(out_instr), 128'h00100093);
        out_ready = 1'b1;
        offer(mk(32'h00300193, 32'h208, 3'd1, 12'h003, 20'h0, 1'b0));
        idle(5);

        // Flush while full, with an instruction offered in the same cycle
        out_ready = 1'b0;
        offer(mk(32'h00400213, 32'h300, 3'd1, 12'h004, 20'h0, 1'b0));
        offer(mk(32'h00500293, 32'h304, 3'd1, 12'h005, 20'h0, 1'b0));
        in_valid = 1'b1;
        in_instr = 32'h00600313;
        in_pc    = 32'h308;
        cur_exp  = mk(32'h00600313, 32'h308, 3'd1, 12'h006, 20'h0, 1'b0);
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 128'(out_valid), 128'd0);
        check("flush_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b1;
        idle(4);
        offer(mk(32'h00700393, 32'h30C, 3'd1, 12'h007, 20'h0, 1'b0));
        idle(3);

        // Asynchronous reset with entries held
        out_ready = 1'b0;
        offer(mk(32'h00800413, 32'h400, 3'd1, 12'h008, 20'h0, 1'b0));
        offer(mk(32'h00900493, 32'h404, 3'd1, 12'h009, 20'h0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 128'(out_valid), 128'd0);
        check("rst_mid_ready", 128'(in_ready), 128'd1);
        check("rst_mid_data", 128'(out_word()), 128'd0);
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(4);

        check("drain", 128'(q.size()), 128'd0);
        check("pop_count", 128'(n_pops), 128'd12);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imm_field_decode.md
# imm_field_decode

Decode-side pipeline stage that sits directly upstream of the sign extenders. It accepts fetched instructions over a valid/ready handshake, classifies the RISC-V base-ISA format, and extracts the raw immediate bits. It registers the result behind a two-entry skid buffer. `out_imm12` feeds a 12→32 sign extender and `out_imm20` feeds a 20→32 sign extender; left shifts for B/U/J are applied downstream.

## Interface
- PC_WIDTH, 32, width of the program counter carried alongside each instruction
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_instr  input  32  instruction word
- in_pc  input  PC_WIDTH  instruction address
- out_valid  output  1  decoded entry available
- out_ready  input  1  downstream accepts
- out_instr  output  32  registered instruction word
- out_pc  output  PC_WIDTH  registered PC
- out_fmt  output  3  format code (package enum)
- out_imm12  output  12  raw 12-bit immediate for I/S/B, else 0
- out_imm20  output  20  raw 20-bit immediate for U/J, else 0
- out_illegal  output  1  opcode not recognised

## Operation
- Format codes: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- Opcode mapping (instr[6:0]):
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - anything else → ILL
- imm12:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8]} (imm[12:1])
  - all other formats: 0
- imm20:
  - U = instr[31:12]
  - J = {instr[31], instr[19:12], instr[20], instr[30:21]} (imm[20:1])
  - all other formats: 0
- Decode is combinational on the input side. The decoded entry (instr, pc, fmt, imm12, imm20, illegal) is what gets stored.
- Buffer FSM:
  - EMPTY: out_valid=0, in_ready=1. Accept → ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept without pop → TWO (new entry goes to skid).
    - Pop without accept → EMPTY.
    - Accept and pop → ONE (new entry to main).
  - TWO: out_valid=1, in_ready=0.
    - Pop → ONE (skid moves to main).
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Ordering is strictly FIFO.

## Timing
- Latency: an instruction accepted on edge N is visible with out_valid=1 after edge N (one cycle), when the buffer was EMPTY or popping.
- in_ready is a pure function of registered state. There is no combinational path from out_ready to in_ready.
- Full throughput of one instruction per cycle when out_ready is held high.
- Output data holds stable while out_valid=1 and out_ready=0.
- flush: on the next edge the state goes to EMPTY and both entries are discarded. An accept in the same cycle is dropped. flush overrides accept and pop.
- Reset (async assert, synchronous deassert is handled upstream):
  - state EMPTY
  - out_valid=0, in_ready=1
  - out_instr, out_pc, out_fmt, out_imm12, out_imm20, out_illegal all 0
- Reset mid-operation discards all entries immediately.

## Configuration
- ILLEGAL_OPCODE_CHECK_EN defined:
  - unlisted opcodes give out_fmt=ILL and out_illegal=1
  - both immediates are 0
- ILLEGAL_OPCODE_CHECK_EN not defined:
  - out_illegal is tied 0
  - unlisted opcodes decode as I format; imm12 = instr[31:20]

## Structure
- Shared package `decode_pkg` holds:
  - `imm_fmt_e` enum (3-bit codes above)
  - opcode localparams
  - IMM12_W=12 and IMM20_W=20
  - the packed `dec_entry_t` struct
- One sub-module: `imm_extract`, the combinational instr → {fmt, imm12, imm20, illegal} decoder. The top holds the two-entry buffer and FSM.

## Test plan
- Basic decode, 0xFFF00093 (addi x1,x0,-1), out_ready=1 → one cycle later fmt=I, imm12=0xFFF, imm20=0.
- S, B and U decode:
  - 0xFE20AE23 (sw x2,-4(x1)) → fmt=S, imm12=0xFFC
  - 0xFE000CE3 (beq x0,x0,-8) → fmt=B, imm12=0xFFC
  - 0x123450B7 (lui) → fmt=U, imm20=0x12345
- J decode, 0xFFDFF06F (jal x0,-4) → fmt=J, imm20=0xFFFFE, imm12=0.
- Backpressure: hold out_ready=0 and offer three instructions back to back → first two accepted, in_ready=0 on the third. Then release out_ready → outputs arrive in order, third accepted, no loss or duplication.
- Flush while in TWO with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle instruction never appears.
- Illegal opcode and reset:
  - With ILLEGAL_OPCODE_CHECK_EN defined, 0x0000007F → fmt=7, out_illegal=1.
  - Assert rst_n=0 mid-stream → all outputs 0 and in_ready=1 immediately.
